// File: rtl/trig_source_mux_if.sv
// Bus bundle for trig_source_mux: trigger source controls in, accepted trigger and status out.
// master drives the source/configuration side, slave is the combiner itself.
interface trig_source_mux_if #(
  parameter int NUM_SRC       = 4,
  parameter int PRESCALE_BITS = 8,
  parameter int HOLDOFF_BITS  = 16
);
  logic [NUM_SRC-1:0]               src_i;
  logic [NUM_SRC-1:0]               src_en_i;
  logic [NUM_SRC*PRESCALE_BITS-1:0] src_prescale_i;
  logic                             disable_i;
  logic [HOLDOFF_BITS-1:0]          holdoff_i;
  logic                             trig_o;
  logic                             trig_out_o;
  logic [NUM_SRC-1:0]               trig_src_o;
  logic                             busy_o;
  logic [31:0]                      trig_count_o;
  logic [15:0]                      veto_count_o;
  logic                             state_dbg_o;

  modport master (
    output src_i, src_en_i, src_prescale_i, disable_i, holdoff_i,
    input  trig_o, trig_out_o, trig_src_o, busy_o, trig_count_o, veto_count_o, state_dbg_o
  );

  modport slave (
    input  src_i, src_en_i, src_prescale_i, disable_i, holdoff_i,
    output trig_o, trig_out_o, trig_src_o, busy_o, trig_count_o, veto_count_o, state_dbg_o
  );
endinterface

// File: rtl/trig_source_mux.sv
// Trigger-source combiner: per-source edge detect, enable and prescale, then global disable and holdoff.
// Define TRIG_MUX_VETO_COUNT_EN to build the saturating veto counter; otherwise veto_count_o reads 0.
module trig_source_mux #(
  parameter int NUM_SRC       = 4,
  parameter int PRESCALE_BITS = 8,
  parameter int HOLDOFF_BITS  = 16,
  parameter int OUT_WIDTH     = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  trig_source_mux_if.slave    bus
);

  localparam int SW = (OUT_WIDTH < 2) ? 1 : $clog2(OUT_WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [NUM_SRC-1:0]        src_q;
  logic [NUM_SRC-1:0]        src_edge;
  logic [NUM_SRC-1:0]        qual;
  logic [NUM_SRC-1:0]        qual_q;
  logic [PRESCALE_BITS-1:0]  pc [NUM_SRC];
  logic [HOLDOFF_BITS-1:0]   hcnt_q;
  logic [SW-1:0]             stretch_q;
  logic                      trig_q;
  logic [NUM_SRC-1:0]        trig_src_q;
  logic [31:0]               trig_cnt_q;
  logic                      accept;

  // Qualification is registered so the accept decision sees a clean one-cycle qual_q pulse.
  always_comb begin
    src_edge = bus.src_i & ~src_q & bus.src_en_i;
    qual     = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      if (src_edge[n] && (pc[n] == bus.src_prescale_i[n*PRESCALE_BITS +: PRESCALE_BITS])) begin
        qual[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      src_q  <= '0;
      qual_q <= '0;
      for (int n = 0; n < NUM_SRC; n++) pc[n] <= '0;
    end else begin
      src_q  <= bus.src_i;
      qual_q <= qual;
      // Counters run free of disable/holdoff; a lowered P lets pc wrap through all-ones.
      for (int n = 0; n < NUM_SRC; n++) begin
        if (src_edge[n]) pc[n] <= qual[n] ? '0 : pc[n] + 1'b1;
      end
    end
  end

  // trig_o is a free-running pulse with no backpressure: the consumer must take it the cycle it is high.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|qual_q && !bus.disable_i) begin
          accept = 1'b1;
          if (bus.holdoff_i != '0) state_d = HOLD;
        end
      end
      HOLD: begin
        if (hcnt_q == HOLDOFF_BITS'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      stretch_q  <= '0;
      trig_q     <= 1'b0;
      trig_src_q <= '0;
      trig_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= accept;
      if (accept) begin
        hcnt_q     <= bus.holdoff_i;
        stretch_q  <= SW'(OUT_WIDTH);
        trig_src_q <= qual_q;
        trig_cnt_q <= trig_cnt_q + 32'd1;
      end else begin
        if (state_q == HOLD) hcnt_q <= hcnt_q - 1'b1;
        if (stretch_q != '0) stretch_q <= stretch_q - 1'b1;
      end
    end
  end

  assign bus.trig_o       = trig_q;
  assign bus.trig_out_o   = (stretch_q != '0);
  assign bus.trig_src_o   = trig_src_q;
  assign bus.busy_o       = (state_q == HOLD);
  assign bus.trig_count_o = trig_cnt_q;
  assign bus.state_dbg_o  = state_q;

`ifdef TRIG_MUX_VETO_COUNT_EN
  logic        veto;
  logic [15:0] veto_cnt_q;

  // One veto per cycle with any qualifier that was not taken, however many bits were set.
  assign veto = |qual_q && !accept;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      veto_cnt_q <= '0;
    end else if (veto && (veto_cnt_q != 16'hFFFF)) begin
      veto_cnt_q <= veto_cnt_q + 16'd1;
    end
  end

  assign bus.veto_count_o = veto_cnt_q;
`else
  assign bus.veto_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_trig_source_mux.sv
// Directed bench for trig_source_mux: latency, stretch, prescale, holdoff boundary, disable, enable, reset.
module tb_trig_source_mux;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #2 clk = ~clk;

  trig_source_mux_if #(.NUM_SRC(4), .PRESCALE_BITS(8), .HOLDOFF_BITS(16)) bus ();

  trig_source_mux #(
    .NUM_SRC(4), .PRESCALE_BITS(8), .HOLDOFF_BITS(16), .OUT_WIDTH(4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected veto count depends on whether the counter is built.
  function automatic logic [31:0] ev(input logic [31:0] n);
`ifdef TRIG_MUX_VETO_COUNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  // Rising edge on mask, released one cycle later; returns two cycles after the drive.
  task automatic pulse(input logic [3:0] mask);
    bus.src_i = mask;
    tick();
    bus.src_i = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.src_i          = '0;
    bus.src_en_i       = 4'b1111;
    bus.src_prescale_i = '0;
    bus.disable_i      = 1'b0;
    bus.holdoff_i      = '0;

    // Reset state
    repeat (3) tick();
    check("rst_trig",      32'(bus.trig_o),       32'd0);
    check("rst_trig_out",  32'(bus.trig_out_o),   32'd0);
    check("rst_trig_src",  32'(bus.trig_src_o),   32'd0);
    check("rst_busy",      32'(bus.busy_o),       32'd0);
    check("rst_trig_cnt",  bus.trig_count_o,      32'd0);
    check("rst_veto_cnt",  32'(bus.veto_count_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single source, P=0, H=0: one-cycle latency, 4-cycle stretch
    bus.src_i = 4'b0001;
    tick();
    check("lat_trig_early", 32'(bus.trig_o), 32'd0);
    bus.src_i = 4'b0000;
    tick();
    check("s1_trig",     32'(bus.trig_o),     32'd1);
    check("s1_trig_out", 32'(bus.trig_out_o), 32'd1);
    check("s1_src",      32'(bus.trig_src_o), 32'h1);
    check("s1_cnt",      bus.trig_count_o,    32'd1);
    tick();
    check("s1_trig_off", 32'(bus.trig_o),     32'd0);
    check("s1_out_c2",   32'(bus.trig_out_o), 32'd1);
    tick();
    tick();
    check("s1_out_c4",   32'(bus.trig_out_o), 32'd1);
    tick();
    check("s1_out_end",  32'(bus.trig_out_o), 32'd0);

    // Prescale 3 on source 1: every 4th edge triggers
    bus.src_prescale_i = 32'h0000_0300;
    for (int i = 1; i <= 12; i++) begin
      pulse(4'b0010);
      check($sformatf("pre_edge%0d", i), 32'(bus.trig_o), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    tick();
    check("pre_cnt",  bus.trig_count_o,      32'd4);
    check("pre_veto", 32'(bus.veto_count_o), ev(32'd0));
    check("pre_src",  32'(bus.trig_src_o),   32'h2);
    bus.src_prescale_i = '0;

    // Holdoff 100: t=0 is the first HOLD cycle
    bus.holdoff_i = 16'd100;
    pulse(4'b0001);
    check("ho_trig", 32'(bus.trig_o), 32'd1);
    check("ho_busy", 32'(bus.busy_o), 32'd1);
    check("ho_cnt",  bus.trig_count_o, 32'd5);
    repeat (30) tick();
    pulse(4'b0001);
    check("ho_veto_trig", 32'(bus.trig_o),       32'd0);
    check("ho_veto_busy", 32'(bus.busy_o),       32'd1);
    check("ho_veto_cnt",  32'(bus.veto_count_o), ev(32'd1));
    repeat (66) tick();
    bus.src_i = 4'b0100;
    tick();
    check("ho_last_busy", 32'(bus.busy_o), 32'd1);
    bus.holdoff_i = 16'd0;
    bus.src_i = 4'b0110;
    tick();
    check("ho_bound_trig", 32'(bus.trig_o),       32'd0);
    check("ho_end_busy",   32'(bus.busy_o),       32'd0);
    check("ho_bound_veto", 32'(bus.veto_count_o), ev(32'd2));
    bus.src_i = 4'b0000;
    tick();
    check("ho_re_trig", 32'(bus.trig_o),     32'd1);
    check("ho_re_src",  32'(bus.trig_src_o), 32'h2);
    check("ho_re_busy", 32'(bus.busy_o),     32'd0);
    check("ho_re_cnt",  bus.trig_count_o,    32'd6);

    // Simultaneous sources: one trigger, both bits
    pulse(4'b0101);
    check("sim_trig", 32'(bus.trig_o),     32'd1);
    check("sim_src",  32'(bus.trig_src_o), 32'h5);
    check("sim_cnt",  bus.trig_count_o,    32'd7);
    tick();
    check("sim_once", 32'(bus.trig_o),     32'd0);
    check("sim_hold", 32'(bus.trig_src_o), 32'h5);

    // H=0 back-to-back accepts on successive sources
    bus.src_i = 4'b0001;
    tick();
    bus.src_i = 4'b0011;
    tick();
    check("b2b_1_trig", 32'(bus.trig_o),     32'd1);
    check("b2b_1_src",  32'(bus.trig_src_o), 32'h1);
    bus.src_i = 4'b0111;
    tick();
    check("b2b_2_trig", 32'(bus.trig_o),     32'd1);
    check("b2b_2_src",  32'(bus.trig_src_o), 32'h2);
    bus.src_i = 4'b0000;
    tick();
    check("b2b_3_trig", 32'(bus.trig_o),     32'd1);
    check("b2b_3_src",  32'(bus.trig_src_o), 32'h4);
    check("b2b_cnt",    bus.trig_count_o,    32'd10);
    tick();
    check("b2b_end",     32'(bus.trig_o),     32'd0);
    check("b2b_stretch", 32'(bus.trig_out_o), 32'd1);

    // Global disable vetoes; disabled source is ignored entirely
    bus.disable_i = 1'b1;
    pulse(4'b1000);
    check("dis_trig", 32'(bus.trig_o),       32'd0);
    check("dis_cnt",  bus.trig_count_o,      32'd10);
    check("dis_veto", 32'(bus.veto_count_o), ev(32'd3));
    bus.disable_i = 1'b0;
    bus.src_en_i  = 4'b0111;
    pulse(4'b1000);
    check("en_trig", 32'(bus.trig_o),       32'd0);
    check("en_cnt",  bus.trig_count_o,      32'd10);
    check("en_veto", 32'(bus.veto_count_o), ev(32'd3));
    bus.src_en_i = 4'b1111;

`ifdef TRIG_MUX_VETO_COUNT_EN
    // Veto counter saturation under a long disabled burst
    bus.disable_i = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      bus.src_i = (i % 2 == 1) ? 4'b0101 : 4'b1010;
      tick();
    end
    bus.src_i = 4'b0000;
    bus.disable_i = 1'b0;
    tick();
    tick();
    check("sat_veto", 32'(bus.veto_count_o), 32'h0000_FFFF);
    check("sat_cnt",  bus.trig_count_o,      32'd10);
`endif

    // Reset in the middle of a long holdoff
    bus.holdoff_i = 16'd1000;
    pulse(4'b0001);
    check("rh_trig", 32'(bus.trig_o), 32'd1);
    check("rh_busy", 32'(bus.busy_o), 32'd1);
    repeat (20) tick();
    rst_n = 1'b0;
    bus.holdoff_i = 16'd0;
    bus.src_i = 4'b0001;
    tick();
    check("rh_busy0", 32'(bus.busy_o),       32'd0);
    check("rh_cnt0",  bus.trig_count_o,      32'd0);
    check("rh_veto0", 32'(bus.veto_count_o), 32'd0);
    check("rh_src0",  32'(bus.trig_src_o),   32'd0);
    check("rh_out0",  32'(bus.trig_out_o),   32'd0);
    rst_n = 1'b1;
    tick();
    check("rh_rel_trig", 32'(bus.trig_o), 32'd0);
    tick();
    check("rh_new_trig", 32'(bus.trig_o),     32'd1);
    check("rh_new_src",  32'(bus.trig_src_o), 32'h1);
    check("rh_new_cnt",  bus.trig_count_o,    32'd1);
    bus.src_i = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
